// File: rtl/nnrv_pkg.sv
// Shared RV32I opcode constants, instruction classes and immediate formats
// for the nnrv decode stage.
package nnrv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OPIMM   = 4'd8,
    CLS_OP      = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_SYSTEM  = 4'd11
  } cls_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/nnrv_imm_gen.sv
// Combinational RV32I immediate extraction; every format sign-extends from inst[31].
module nnrv_imm_gen
  import nnrv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/nnrv_decode.sv
// RV32I decode / operand-fetch stage: same-cycle register-file read with
// write-back bypass, one registered output slot toward execute.
module nnrv_decode
  import nnrv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_valid,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_inst_ready,
  output logic            o_r1_en,
  output logic            o_r2_en,
  output logic [4:0]      o_r1,
  output logic [4:0]      o_r2,
  input  logic [XLEN-1:0] i_r1_reg,
  input  logic [XLEN-1:0] i_r2_reg,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb,
  input  logic [XLEN-1:0] i_wb_reg,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output cls_e            o_class,
  output logic [2:0]      o_funct3,
  output logic            o_alt,
  output logic [4:0]      o_rd,
  output logic            o_rd_en,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_idx;
  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];
  assign rd_idx = i_inst[11:7];
  assign o_r1   = i_inst[19:15];
  assign o_r2   = i_inst[24:20];

  cls_e     cls_raw, cls_next;
  logic     illegal_next;
  imm_fmt_e fmt;
  logic     rd_writes;
  logic [XLEN-1:0] imm_next, rs1_val_next, rs2_val_next;

  always_comb begin
    cls_raw      = CLS_ILLEGAL;
    illegal_next = 1'b0;
    case (opcode)
      OPC_LUI:    cls_raw = CLS_LUI;
      OPC_AUIPC:  cls_raw = CLS_AUIPC;
      OPC_JAL:    cls_raw = CLS_JAL;
      OPC_JALR:   cls_raw = CLS_JALR;
      OPC_FENCE:  cls_raw = CLS_FENCE;
      OPC_SYSTEM: cls_raw = CLS_SYSTEM;
      OPC_BRANCH: begin
        cls_raw      = CLS_BRANCH;
        illegal_next = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        cls_raw      = CLS_LOAD;
        illegal_next = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        cls_raw      = CLS_STORE;
        illegal_next = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        // Only the shift-immediates carry a funct7 field
        cls_raw = CLS_OPIMM;
        if (funct3 == 3'b001) illegal_next = (funct7 != 7'h00);
        if (funct3 == 3'b101) illegal_next = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        cls_raw      = CLS_OP;
        illegal_next = ((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                       ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101));
      end
      default: illegal_next = 1'b1;
    endcase
    if (i_inst[1:0] != 2'b11) illegal_next = 1'b1;
    cls_next = illegal_next ? CLS_ILLEGAL : cls_raw;
  end

  always_comb begin
    o_r1_en   = 1'b0;
    o_r2_en   = 1'b0;
    fmt       = IMM_NONE;
    rd_writes = 1'b0;
    case (cls_next)
      CLS_LUI, CLS_AUIPC: begin fmt = IMM_U; rd_writes = 1'b1; end
      CLS_JAL:            begin fmt = IMM_J; rd_writes = 1'b1; end
      CLS_JALR, CLS_LOAD, CLS_OPIMM: begin
        fmt = IMM_I; o_r1_en = 1'b1; rd_writes = 1'b1;
      end
      CLS_BRANCH: begin fmt = IMM_B; o_r1_en = 1'b1; o_r2_en = 1'b1; end
      CLS_STORE:  begin fmt = IMM_S; o_r1_en = 1'b1; o_r2_en = 1'b1; end
      CLS_OP:     begin o_r1_en = 1'b1; o_r2_en = 1'b1; rd_writes = 1'b1; end
      default: ;
    endcase
  end

  nnrv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (i_inst),
    .fmt  (fmt),
    .imm  (imm_next)
  );

  // The register file commits on the same edge, so a matching write-back wins
  always_comb begin
    rs1_val_next = '0;
    rs2_val_next = '0;
    if (o_r1_en && o_r1 != 5'd0)
      rs1_val_next = (i_wb_en && i_wb == o_r1) ? i_wb_reg : i_r1_reg;
    if (o_r2_en && o_r2 != 5'd0)
      rs2_val_next = (i_wb_en && i_wb == o_r2) ? i_wb_reg : i_r2_reg;
  end

  logic accept;
  assign o_inst_ready = !o_valid || i_ready;
  assign accept       = i_inst_valid && o_inst_ready && !i_flush;

  // Unused sources are stored as index 0 so the hold refresh never matches them
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid   <= 1'b0;
      o_pc      <= RESET_PC;
      o_class   <= CLS_ILLEGAL;
      o_funct3  <= '0;
      o_alt     <= 1'b0;
      o_rd      <= '0;
      o_rd_en   <= 1'b0;
      o_rs1     <= '0;
      o_rs2     <= '0;
      o_rs1_val <= '0;
      o_rs2_val <= '0;
      o_imm     <= '0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_pc      <= i_pc;
      o_class   <= cls_next;
      o_funct3  <= funct3;
      o_alt     <= i_inst[30];
      o_rd      <= rd_idx;
      o_rd_en   <= rd_writes && (rd_idx != 5'd0);
      o_rs1     <= o_r1_en ? o_r1 : 5'd0;
      o_rs2     <= o_r2_en ? o_r2 : 5'd0;
      o_rs1_val <= rs1_val_next;
      o_rs2_val <= rs2_val_next;
      o_imm     <= imm_next;
      o_illegal <= illegal_next;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end else if (o_valid) begin
      if (i_wb_en && i_wb != 5'd0 && i_wb == o_rs1) o_rs1_val <= i_wb_reg;
      if (i_wb_en && i_wb != 5'd0 && i_wb == o_rs2) o_rs2_val <= i_wb_reg;
    end
  end

endmodule

// File: tb/tb_nnrv_decode.sv
// Directed bench for nnrv_decode: reset, bypass, stall refresh, throughput,
// flush, immediates and illegal decode against hand-computed values.
module tb_nnrv_decode;
  import nnrv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_inst_valid;
  logic [31:0] i_inst, i_pc;
  logic        o_inst_ready, o_r1_en, o_r2_en;
  logic [4:0]  o_r1, o_r2;
  logic [31:0] i_r1_reg, i_r2_reg;
  logic        i_wb_en;
  logic [4:0]  i_wb;
  logic [31:0] i_wb_reg;
  logic        i_flush, o_valid, i_ready;
  logic [31:0] o_pc;
  cls_e        o_class;
  logic [2:0]  o_funct3;
  logic        o_alt;
  logic [4:0]  o_rd;
  logic        o_rd_en;
  logic [4:0]  o_rs1, o_rs2;
  logic [31:0] o_rs1_val, o_rs2_val, o_imm;
  logic        o_illegal;

  int checks = 0;
  int errors = 0;

  nnrv_decode #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst_valid(i_inst_valid), .i_inst(i_inst),
    .i_pc(i_pc), .o_inst_ready(o_inst_ready), .o_r1_en(o_r1_en), .o_r2_en(o_r2_en),
    .o_r1(o_r1), .o_r2(o_r2), .i_r1_reg(i_r1_reg), .i_r2_reg(i_r2_reg),
    .i_wb_en(i_wb_en), .i_wb(i_wb), .i_wb_reg(i_wb_reg), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_class(o_class),
    .o_funct3(o_funct3), .o_alt(o_alt), .o_rd(o_rd), .o_rd_en(o_rd_en),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val),
    .o_imm(o_imm), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    i_inst       = inst;
    i_pc         = pc;
    i_inst_valid = 1'b1;
  endtask

  logic [31:0] thr_inst [4];

  initial begin
    i_rst = 1'b0; i_inst_valid = 1'b0; i_inst = '0; i_pc = '0;
    i_r1_reg = '0; i_r2_reg = '0; i_wb_en = 1'b0; i_wb = '0; i_wb_reg = '0;
    i_flush = 1'b0; i_ready = 1'b1;

    // Reset state
    repeat (2) step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, RST_PC);
    check("rst_inst_ready", 32'(o_inst_ready), 32'd1);
    check("rst_class", 32'(o_class), 32'd0);
    i_rst = 1'b1;

    // ADDI x5,x1,-1
    present(32'hFFF08293, 32'h0000_0100);
    i_r1_reg = 32'd10;
    #1;
    check("addi_r1_en", 32'(o_r1_en), 32'd1);
    check("addi_r1", 32'(o_r1), 32'd1);
    check("addi_r2_en", 32'(o_r2_en), 32'd0);
    step();
    check("addi_valid", 32'(o_valid), 32'd1);
    check("addi_class", 32'(o_class), 32'(CLS_OPIMM));
    check("addi_rd", 32'(o_rd), 32'd5);
    check("addi_rd_en", 32'(o_rd_en), 32'd1);
    check("addi_rs1_val", o_rs1_val, 32'd10);
    check("addi_imm", o_imm, 32'hFFFF_FFFF);
    check("addi_pc", o_pc, 32'h0000_0100);

    // ADD x3,x1,x2 with write-back bypass on x2
    present(32'h002081B3, 32'h0000_0104);
    i_r1_reg = 32'h7; i_r2_reg = 32'h11;
    i_wb_en = 1'b1; i_wb = 5'd2; i_wb_reg = 32'h55;
    step();
    check("byp_rs1_val", o_rs1_val, 32'h7);
    check("byp_rs2_val", o_rs2_val, 32'h55);
    check("byp_class", 32'(o_class), 32'(CLS_OP));

    // ADD x3,x0,x0 with write-back to x0: operands stay 0
    present(32'h000001B3, 32'h0000_0108);
    i_wb = 5'd0; i_wb_reg = 32'h99;
    step();
    check("x0_rs1_val", o_rs1_val, 32'h0);
    check("x0_rs2_val", o_rs2_val, 32'h0);
    i_wb_en = 1'b0;

    // SW x2,4(x1) then stall with write-back refresh of x2
    present(32'h0020A223, 32'h0000_0200);
    i_r1_reg = 32'h100; i_r2_reg = 32'h200;
    step();
    i_inst_valid = 1'b0; i_ready = 1'b0;
    #1;
    check("sw_class", 32'(o_class), 32'(CLS_STORE));
    check("sw_imm", o_imm, 32'd4);
    check("sw_rd_en", 32'(o_rd_en), 32'd0);
    check("sw_rs2_val", o_rs2_val, 32'h200);
    check("stall_inst_ready", 32'(o_inst_ready), 32'd0);
    i_wb_en = 1'b1; i_wb = 5'd2; i_wb_reg = 32'hABCD;
    step();
    check("stall_rs2_val", o_rs2_val, 32'hABCD);
    check("stall_rs1_val", o_rs1_val, 32'h100);
    check("stall_valid", 32'(o_valid), 32'd1);
    check("stall_pc", o_pc, 32'h0000_0200);
    check("stall_imm", o_imm, 32'd4);
    check("stall_rs2", 32'(o_rs2), 32'd2);
    check("stall_inst_ready2", 32'(o_inst_ready), 32'd0);
    i_wb = 5'd5; i_wb_reg = 32'h1234;
    step();
    check("stall_unrel_rs1", o_rs1_val, 32'h100);
    check("stall_unrel_rs2", o_rs2_val, 32'hABCD);
    i_wb_en = 1'b0;

    // Back-to-back with flush on the 3rd
    thr_inst[0] = 32'h00108093;  // addi x1,x1,1
    thr_inst[1] = 32'h00210113;  // addi x2,x2,2
    thr_inst[2] = 32'h00318193;  // addi x3,x3,3
    thr_inst[3] = 32'h00420213;  // addi x4,x4,4
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      present(thr_inst[k], 32'h0000_0300 + 32'(4 * k));
      i_flush = (k == 2);
      step();
      if (k == 2) begin
        check("flush_valid", 32'(o_valid), 32'd0);
      end else begin
        check($sformatf("thr%0d_valid", k), 32'(o_valid), 32'd1);
        check($sformatf("thr%0d_pc", k), o_pc, 32'h0000_0300 + 32'(4 * k));
        check($sformatf("thr%0d_rd", k), 32'(o_rd), 32'(k + 1));
      end
    end
    i_flush = 1'b0;

    // Immediates
    present(32'hFE000EE3, 32'h0000_0400);  // beq x0,x0,-4
    step();
    check("beq_class", 32'(o_class), 32'(CLS_BRANCH));
    check("beq_imm", o_imm, 32'hFFFF_FFFC);
    present(32'h001000EF, 32'h0000_0404);  // jal x1,+2048
    step();
    check("jal_class", 32'(o_class), 32'(CLS_JAL));
    check("jal_imm", o_imm, 32'h0000_0800);
    check("jal_rd_en", 32'(o_rd_en), 32'd1);
    present(32'h123452B7, 32'h0000_0408);  // lui x5,0x12345
    step();
    check("lui_class", 32'(o_class), 32'(CLS_LUI));
    check("lui_imm", o_imm, 32'h1234_5000);

    // Illegal encodings and rd = x0
    present(32'h0000_0000, 32'h0000_0500);
    step();
    check("ill0_illegal", 32'(o_illegal), 32'd1);
    check("ill0_class", 32'(o_class), 32'd0);
    check("ill0_rd_en", 32'(o_rd_en), 32'd0);
    present(32'h022081B3, 32'h0000_0504);  // funct7=0x01 on OP
    step();
    check("illf7_illegal", 32'(o_illegal), 32'd1);
    check("illf7_class", 32'(o_class), 32'd0);
    present(32'h00208033, 32'h0000_0508);  // add x0,x1,x2
    step();
    check("addx0_rd_en", 32'(o_rd_en), 32'd0);
    check("addx0_class", 32'(o_class), 32'(CLS_OP));
    check("addx0_illegal", 32'(o_illegal), 32'd0);

    i_inst_valid = 1'b0;
    step();
    check("drain_valid", 32'(o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nnrv_decode.md
Name: nnrv_decode

Overview:
RV32I decode/operand-fetch stage sitting between instruction fetch and execute in the nnrv core. Accepts one instruction per cycle over a valid/ready handshake and drives the register-file read ports combinationally (same cycle). It applies write-back bypass, generates the immediate and instruction class, and registers the result into a single pipeline slot toward execute. It also keeps stalled operands coherent with later write-backs.

Parameters:
XLEN, 32, datapath width; only 32 supported.
RESET_PC, 32'h0, value driven on o_pc while the stage is reset (payload reset value).

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-low reset (0 = reset)
i_inst_valid  in  1  fetch has an instruction
i_inst  in  32  instruction word
i_pc  in  XLEN  instruction address
o_inst_ready  out  1  stage can accept this cycle
o_r1_en / o_r2_en  out  1  register-file read enables
o_r1 / o_r2  out  5  register-file read indices
i_r1_reg / i_r2_reg  in  XLEN  register-file read data, same cycle
i_wb_en  in  1  write-back valid this cycle (same signal as register-file write enable)
i_wb  in  5  write-back index
i_wb_reg  in  XLEN  write-back data
i_flush  in  1  kill the held and incoming instruction (branch redirect)
o_valid  out  1  decoded instruction available
i_ready  in  1  execute accepts
o_pc  out  XLEN  instruction address
o_class  out  4  instruction class (package enum)
o_funct3  out  3  inst[14:12]
o_alt  out  1  inst[30] (SUB/SRA select)
o_rd  out  5  destination index
o_rd_en  out  1  instruction writes rd and rd != 0
o_rs1 / o_rs2  out  5  source indices, kept for hazard logic downstream
o_rs1_val / o_rs2_val  out  XLEN  operand values
o_imm  out  XLEN  sign-extended immediate
o_illegal  out  1  unrecognised opcode/funct

Behaviour:
- Reset (i_rst=0, asynchronous): o_valid=0; o_pc=RESET_PC; all other registered outputs 0; o_class=CLS_ILLEGAL encoded as 0.
- o_inst_ready = !o_valid || i_ready (combinational); accept = i_inst_valid && o_inst_ready && !i_flush.
- Read ports decode from i_inst every cycle regardless of i_inst_valid.
  - o_r1_en=1 for JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - o_r2_en=1 for BRANCH, STORE, OP.
  - Both enables 0 otherwise.
- Operand select, per source:
  - If enable=0 or index=0, the value is 0.
  - Else, if i_wb_en && i_wb==index, the value is i_wb_reg (bypass: the register file commits on the same edge).
  - Else, the value is i_rN_reg.
- Latency: one cycle. The accepted instruction appears on o_* after the next rising edge.
- Hold (o_valid && !i_ready): the payload is stable, except that on each cycle with i_wb_en && i_wb!=0 && i_wb==o_rsN && the source is used, o_rsN_val is updated to i_wb_reg.
- Slot state transitions:
  - Slot empties when o_valid && i_ready && !accept.
  - Slot refills when accept occurs, even in the same cycle as consume.
- i_flush=1: o_valid cleared at the next edge and nothing is accepted that cycle; flush has priority over accept and hold.
- Immediates, all formats sign-extended from inst[31]:
  - I-type: JALR, LOAD, OPIMM.
  - S-type: STORE.
  - B-type: BRANCH, bit0 = 0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit0 = 0.
  - Other classes: 0.
- o_rd_en=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP when rd!=0; otherwise 0.
- o_illegal=1 for any of:
  - opcode not in the RV32I base set, or inst[1:0]!=2'b11;
  - OP with funct7 not in {0x00, 0x20}, or 0x20 with funct3 not in {000, 101};
  - OPIMM shifts with illegal funct7;
  - LOAD with funct3 in {011, 110, 111};
  - STORE with funct3 > 010;
  - BRANCH with funct3 in {010, 011}.
  When illegal: o_class=CLS_ILLEGAL, o_rd_en=0.
- FENCE and SYSTEM (ECALL/EBREAK/CSR opcode) decode to their classes without operands beyond the rules above.

Decomposition:
- Package nnrv_pkg holds:
  - opcode constants (OPC_LUI=7'b0110111 … OPC_SYSTEM=7'b1110011);
  - the 4-bit class enum: CLS_ILLEGAL=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM;
  - the immediate-format enum.
- One combinational sub-module, nnrv_imm_gen (instruction in, format in, XLEN immediate out), is natural.
- Class, illegal and operand-select logic stay in nnrv_decode.

Test Plan:
- Reset: hold i_rst=0 → o_valid=0, o_pc=RESET_PC, o_inst_ready=1. Release, feed ADDI x5,x1,-1 (0xFFF08293) with i_r1_reg=10 → next cycle o_class=OPIMM, o_rd=5, o_rd_en=1, o_rs1_val=10, o_imm=0xFFFFFFFF.
- Bypass: feed ADD x3,x1,x2 (0x002081B3) while i_wb_en=1, i_wb=2, i_wb_reg=0x55, i_r2_reg=0x11 → o_rs2_val=0x55. Repeat with i_wb=0 and index 0 → operand 0.
- Stall refresh: hold i_ready=0 with SW x2,4(x1) in the slot, then pulse i_wb_en for x2 with 0xABCD → o_rs2_val=0xABCD, all other outputs unchanged, o_inst_ready=0.
- Back-to-back throughput and flush: 4 instructions with i_ready=1 → one output per cycle, in order. Assert i_flush in the cycle the 3rd is presented → the 3rd is dropped, o_valid=0 next cycle.
- Immediates: BEQ with offset -4 (0xFE000EE3) → o_imm=0xFFFFFFFC. JAL with offset 2048 → o_imm=0x800. LUI 0x12345 → o_imm=0x12345000.
- Illegal and x0: opcode 0x00000000 → o_illegal=1, o_class=0, o_rd_en=0. ADD x0,x1,x2 → o_rd_en=0.
